// File: rtl/ysyx_25050147_ifu.sv
// ysyx_25050147_ifu: instruction fetch unit that owns the architectural PC.
//
// It fetches one 32-bit instruction at a time over a valid/ready request
// channel and a single-beat response channel. It holds the instruction for
// the consumer and then advances the PC, either sequentially or to a redirect
// target. A fetch fault (a misaligned PC or a memory error) is turned into
// FAULT_INST, so the core halts through its normal ebreak path.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   imem_req_valid/ready/addr fetch request; addr always equals pc
//   imem_resp_valid/data/err  fetch response; only looked at in WAIT
//   inst_valid/ready          handshake with the decode/execute consumer
//   inst, inst_pc, inst_fault instruction being held and its PC
//   redirect_valid/pc         next-PC override, sampled only on consume
//   pc                        current fetch PC
//   fetch_count               instructions consumed since reset (wraps)
//
// state | meaning
// ------+-------------------------------------------------------------------
// REQ   | presenting pc to memory, or substituting a fault if pc misaligned
// WAIT  | request accepted, waiting (unbounded) for the response beat
// HOLD  | instruction valid for the consumer until inst_ready
module ysyx_25050147_ifu #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] FAULT_INST = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_d;
    logic [31:0] inst_d;
    logic [31:0] inst_pc_d;
    logic        inst_fault_d;
    logic [31:0] fetch_count_d;
    logic        pc_misaligned;

    assign pc_misaligned = |pc[1:0];

    // Both handshake outputs come only from registered state, so neither one
    // has a combinational path from inst_ready or imem_req_ready.
    assign imem_req_addr  = pc;
    assign imem_req_valid = (state_q == REQ) && !pc_misaligned;
    assign inst_valid     = (state_q == HOLD);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc;
        inst_d        = inst;
        inst_pc_d     = inst_pc;
        inst_fault_d  = inst_fault;
        fetch_count_d = fetch_count;
        case (state_q)
            REQ: begin
                // A misaligned PC never reaches memory. The fault is
                // delivered straight away as if it were a fetched word.
                if (pc_misaligned) begin
                    inst_d       = FAULT_INST;
                    inst_fault_d = 1'b1;
                    inst_pc_d    = pc;
                    state_d      = HOLD;
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    inst_d       = imem_resp_err ? FAULT_INST : imem_resp_data;
                    inst_fault_d = imem_resp_err;
                    inst_pc_d    = pc;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    pc_d          = redirect_valid ? redirect_pc : pc + 32'd4;
                    fetch_count_d = fetch_count + 32'd1;
                    state_d       = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= REQ;
            pc          <= RESET_PC;
            inst        <= 32'd0;
            inst_pc     <= RESET_PC;
            inst_fault  <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            inst        <= inst_d;
            inst_pc     <= inst_pc_d;
            inst_fault  <= inst_fault_d;
            fetch_count <= fetch_count_d;
        end
    end

endmodule

// File: doc/ysyx_25050147_ifu.md
# ysyx_25050147_ifu

Instruction fetch unit placed directly upstream of the single-cycle core datapath; it owns the architectural PC. It fetches one 32-bit instruction at a time from instruction memory over a valid/ready request channel plus a response channel. It presents the instruction and its PC to the decode/execute logic, then advances the PC either sequentially or to a redirect target when the instruction is consumed. Fetch faults are converted into an `ebreak` so the core halts through its existing ebreak path.

## Interface
- `RESET_PC`, default 32'h80000000: PC value loaded on reset.
- `FAULT_INST`, default 32'h00100073 (ebreak): instruction substituted on any fetch fault.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: fetch address, always equal to `pc`.
- `imem_resp_valid` in 1: response valid, one cycle per accepted request.
- `imem_resp_data` in 32: instruction word.
- `imem_resp_err` in 1: access error, qualified by `imem_resp_valid`.
- `inst_valid` out 1: `inst`/`inst_pc`/`inst_fault` valid for the consumer.
- `inst_ready` in 1: consumer takes the instruction this cycle.
- `inst` out 32: fetched instruction, or `FAULT_INST` on a fault.
- `inst_pc` out 32: PC of `inst`.
- `inst_fault` out 1: the current instruction is a fault substitute.
- `redirect_valid` in 1: next PC is `redirect_pc` (jump/branch taken); sampled only on consume.
- `redirect_pc` in 32: redirect target.
- `pc` out 32: current architectural fetch PC.
- `fetch_count` out 32: number of instructions consumed since reset; wraps modulo 2^32.

## Operation
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - `imem_req_valid`=1 and `imem_req_addr`=`pc`.
  - If `pc[1:0]`≠0: no request is issued (`imem_req_valid`=0). Load `inst`=`FAULT_INST` and `inst_fault`=1, then go to HOLD.
  - Otherwise, on `imem_req_valid && imem_req_ready`, go to WAIT.
  - Request address and valid stay stable until accepted.
- WAIT:
  - On `imem_resp_valid`, latch `inst` = `imem_resp_err` ? `FAULT_INST` : `imem_resp_data`.
  - Latch `inst_fault`=`imem_resp_err` and `inst_pc`=`pc`, then go to HOLD.
  - Remain in WAIT indefinitely with no timeout.
- HOLD:
  - `inst_valid`=1; the outputs hold until `inst_ready`.
  - On `inst_ready`:
    - `pc` ← `redirect_valid` ? `redirect_pc` : `pc`+4 (32-bit, wraps).
    - `fetch_count` increments.
    - Go to REQ.
- `imem_resp_valid` in REQ or HOLD is ignored; it must not alter any output.
- `redirect_valid` outside the HOLD&&`inst_ready` cycle is ignored.
- Reset:
  - `pc`=`RESET_PC`, state=REQ, `inst`=0, `inst_pc`=`RESET_PC`, `inst_fault`=0, `inst_valid`=0, `fetch_count`=0.
  - `imem_req_valid` is 1 in the first cycle after reset if `RESET_PC` is aligned.
- Reset mid-operation (in WAIT or HOLD): the state is abandoned immediately with no consume and no count. Instruction memory shares `rst` and drops any outstanding response.

## Timing
- `inst_valid` is a registered state decode (HOLD). `imem_req_valid` is decoded from state plus `pc[1:0]`. Neither depends combinationally on `inst_ready` or `imem_req_ready`.
- Request accepted at edge N → `imem_resp_valid` no earlier than cycle N+1.
- Response at edge M → `inst_valid` from cycle M+1.
- Consume at edge K → new `pc` and `imem_req_valid` in cycle K+1.
- Minimum fetch-to-fetch interval is 3 cycles (REQ, WAIT, HOLD) with a zero-wait memory.
- Misaligned fetch: HOLD is reached 1 cycle after entering REQ.
- A consume and a redirect in the same cycle is the normal jump case; the redirect wins over `pc`+4.

## Test plan
- Reset, zero-wait memory returning 0x00000013 everywhere, `inst_ready`=1 → requests at 0x80000000, 0x80000004, 0x80000008, one every 3 cycles; `fetch_count`=3 after the third consume.
- `imem_req_ready` held low 5 cycles, then high → `imem_req_addr` stable at 0x80000000 throughout; a single request is accepted.
- Response 0xDEADBEEF with `inst_ready` low for 4 cycles → `inst`=0xDEADBEEF and `inst_pc`=0x80000000 held stable; `pc` unchanged until consume.
- Consume with `redirect_valid`=1, `redirect_pc`=0x80000100 → next request at 0x80000100. Consume with `redirect_pc`=0x80000102 → no memory request; `inst`=0x00100073, `inst_fault`=1.
- `imem_resp_err`=1 on fetch at 0x80000004 → `inst`=0x00100073, `inst_fault`=1, `inst_pc`=0x80000004.
- `rst` asserted while in WAIT → next cycle `pc`=0x80000000, `inst_valid`=0, `fetch_count`=0. A spurious `imem_resp_valid` while in REQ is ignored.
